// File: rtl/axis_adc_decimator.sv
// Power-of-two boxcar decimator for the two-lane ADC sample stream.
// Sums 2^L consecutive samples per lane and emits the floor-average on an
// AXI4-Stream master. L is sampled at each block start. A change of L in
// the middle of a block discards the partial block.
module axis_adc_decimator #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int MAX_LOG2         = 8
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [3:0]                  cfg_log2,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        sts_overflow
);

  localparam int                ACC_W   = 16 + MAX_LOG2;
  localparam logic [3:0]        MAX_L   = 4'(MAX_LOG2);
  localparam logic [MAX_LOG2:0] ONE_W   = (MAX_LOG2+1)'(1);
  localparam logic [MAX_LOG2-1:0] CNT_ONE = MAX_LOG2'(1);

  logic                          tready_reg;
  logic [MAX_LOG2-1:0]           cnt_reg, cnt_next;
  logic [3:0]                    l_lat_reg, l_lat_next;
  logic signed [ACC_W-1:0]       acc_reg [2];
  logic signed [ACC_W-1:0]       sum_next [2];
  logic signed [ACC_W-1:0]       shifted [2];
  logic [31:0]                   result_next;
  logic [AXIS_TDATA_WIDTH-1:0]   tdata_reg;
  logic                          tvalid_reg;
  logic                          overflow_reg;

  logic [3:0]                    lc;
  logic                          accept;
  logic                          cfg_chg;
  logic                          start;
  logic [3:0]                    eff_l;
  logic [MAX_LOG2-1:0]           eff_cnt;
  logic [MAX_LOG2:0]             mask_wide;
  logic                          block_end;

  assign s_axis_tready = tready_reg;
  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign sts_overflow  = overflow_reg;

  // Block bookkeeping: a beat starts a fresh block when the counter is idle
  // or when L changed under a partial block. It then uses the new L at once,
  // so L=0 stays a one-beat block even right after a change.
  always_comb begin
    lc        = (cfg_log2 > MAX_L) ? MAX_L : cfg_log2;
    accept    = s_axis_tvalid & tready_reg;
    cfg_chg   = (cnt_reg != '0) && (lc != l_lat_reg);
    start     = (cnt_reg == '0) || cfg_chg;
    eff_l     = start ? lc : l_lat_reg;
    eff_cnt   = start ? '0 : cnt_reg;
    mask_wide = (ONE_W << eff_l) - ONE_W;
    block_end = accept && (eff_cnt == mask_wide[MAX_LOG2-1:0]);

    cnt_next   = cnt_reg;
    l_lat_next = l_lat_reg;
    if (accept) begin
      cnt_next = block_end ? '0 : (eff_cnt + CNT_ONE);
      if (start) l_lat_next = lc;
    end else if (cfg_chg) begin
      cnt_next = '0;
    end
  end

  // Per-lane accumulate and floor-divide by 2^L (arithmetic shift)
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic signed [15:0]      lane;
      logic signed [ACC_W-1:0] lane_ext;

      assign lane          = s_axis_tdata[16*gi +: 16];
      assign lane_ext      = ACC_W'(lane);
      assign sum_next[gi]  = start ? lane_ext : (acc_reg[gi] + lane_ext);
      assign shifted[gi]   = sum_next[gi] >>> eff_l;
      assign result_next[16*gi +: 16] = shifted[gi][15:0];

      // Accumulator register updates only on accepted beats
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) acc_reg[gi] <= '0;
        else if (accept) acc_reg[gi] <= sum_next[gi];
      end
    end
  endgenerate

  // Control state and input ready; ready rises on the first edge after reset
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tready_reg <= 1'b0;
      cnt_reg    <= '0;
      l_lat_reg  <= '0;
    end else begin
      tready_reg <= 1'b1;
      cnt_reg    <= cnt_next;
      l_lat_reg  <= l_lat_next;
    end
  end

  // Output register: a new result always wins; losing an unaccepted one is sticky
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tdata_reg    <= '0;
      tvalid_reg   <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (block_end) begin
      tdata_reg  <= AXIS_TDATA_WIDTH'(result_next);
      tvalid_reg <= 1'b1;
      if (tvalid_reg && !m_axis_tready) overflow_reg <= 1'b1;
    end else if (tvalid_reg && m_axis_tready) begin
      tvalid_reg <= 1'b0;
    end
  end

endmodule

// File: doc/axis_adc_decimator.md
# axis_adc_decimator

Power-of-two boxcar decimator that sits directly downstream of `axis_red_pitaya_adc`. It consumes that block's 32-bit two-channel sample stream and sums 2^L consecutive samples per channel. It then emits the per-channel average on an AXI4-Stream master toward the DMA/FIFO stage. The decimation ratio is runtime-configurable.

## Interface
Parameters:
- `AXIS_TDATA_WIDTH`, default 32: stream width; two 16-bit signed lanes, [15:0] = channel A, [31:16] = channel B.
- `MAX_LOG2`, default 8: largest supported log2 ratio; accumulators are 16+MAX_LOG2 bits.

Ports:
- `aclk`, input, 1: single clock; everything is synchronous to its rising edge.
- `aresetn`, input, 1: reset, asynchronous and active-low.
- `cfg_log2`, input, 4: log2 of the decimation ratio L; values > MAX_LOG2 are clamped to MAX_LOG2.
- `s_axis_tdata`, input, 32: input samples (sign-extended 14-bit ADC codes).
- `s_axis_tvalid`, input, 1: input beat valid.
- `s_axis_tready`, output, 1: 0 in reset, 1 otherwise. The upstream ADC cannot stall, so this block never stalls it.
- `m_axis_tdata`, output, 32: averaged samples, same lane layout as input.
- `m_axis_tvalid`, output, 1: output beat valid.
- `m_axis_tready`, input, 1: downstream accept.
- `sts_overflow`, output, 1: sticky flag; an unaccepted output was overwritten.

## Operation
- State: `cnt` (MAX_LOG2 bits), `acc_a`/`acc_b` (signed, 16+MAX_LOG2 bits), `l_lat` (latched L), output register, `sts_overflow`.
- `Lc` = clamp(`cfg_log2`).
- **Beat acceptance:** an input beat is accepted when `s_axis_tvalid` & `s_axis_tready`. Cycles without a valid beat change nothing except the output handshake.
- **Block start:** on an accepted beat with `cnt`==0, `l_lat` <= `Lc`, and each accumulator <= the sign-extended lane value (not added to the old value).
- **Mid-block beat:** on an accepted beat with `cnt`!=0, each accumulator <= accumulator + sign-extended lane.
- **Block end:** when the accepted beat has `cnt` == 2^`l_lat` − 1:
  - the output register is loaded with the lane sums (including this beat) arithmetically shifted right by `l_lat`, truncated to 16 bits;
  - `cnt` <= 0.
  - Otherwise `cnt` <= `cnt` + 1.
- **Rounding:** the shift is toward −infinity (no rounding). Results always fit in 16 bits, so there is no saturation logic.
- **L = 0:** every accepted beat is a block end, giving pass-through with a register stage.
- **Config change mid-block:** if `cnt`!=0 and `Lc` != `l_lat` in any cycle, the partial block is discarded and no output is produced for it.
  - If no beat is accepted that cycle: `cnt` <= 0.
  - If a beat is accepted that cycle: it is treated as a block start with the new `Lc`.
- **Output register:**
  - `m_axis_tvalid` sets when a result loads.
  - It clears on `m_axis_tvalid` & `m_axis_tready` when no new result loads in that same cycle.
  - Handshake and new load in the same cycle: the new result loads, `tvalid` stays 1, no overflow.
  - New load while `tvalid`=1 and `tready`=0: the new result overwrites, `tvalid` stays 1, `sts_overflow` <= 1.
- `sts_overflow` clears only on reset.

## Timing
- **Reset values:** `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `sts_overflow`=0. Internal: `cnt`=0, accumulators 0, `l_lat`=0.
- **Reset assertion:** asynchronous; the outputs go to reset values immediately, mid-block included.
- **First post-reset edge:** `s_axis_tready` becomes 1 on the first rising edge after `aresetn` deasserts. Beats presented on that edge are not accepted.
- **Latency:** `m_axis_tvalid` is high in the cycle after the edge that accepts the last beat of a block (1 clock).
- **Throughput:** one input beat per clock sustained; one output per 2^L accepted beats.
- **Output hold:** `m_axis_tdata` holds stable while `tvalid`=1 and `tready`=0, except when overwritten under overflow.

## Test plan
- **L=0 ramp:** `tready`=1, A=i, B=i+1 for i=0..511 every clock -> each output equals its input one clock later; 512 outputs; `sts_overflow`=0.
- **L=2 sign handling:** A=1,2,3,4 and B=−1,−2,−3,−4 -> single output 0xFFFD_0002 (A=10>>2=2, B=−10>>>2=−3), `tvalid` high one cycle after the 4th beat.
- **L=8 full scale:** 256 beats of A=0x7FFF, B=0x8000 -> output 0x8000_7FFF, no wrap; gapped `tvalid` (every other clock) gives the same result after 256 valid beats.
- **Backpressure overflow:** L=1, `tready`=0, 4 beats A=2,4,6,8 -> first output 3, then overwritten by 7; `tvalid` stays 1, `sts_overflow`=1. After `tready`=1 the beat carries A=7, then `tvalid`=0; `sts_overflow` stays 1.
- **Mid-block config change:** L=2, 2 beats A=100, then `cfg_log2`=1 with beats A=2,4 -> partial block discarded; single output A=3.
- **Reset mid-block:** L=2, 3 beats, then `aresetn` low for 2 clocks -> outputs 0 immediately. After release, 4 beats A=8 produce A=8, with no contribution from the pre-reset beats.
